uart_receiver: RTL and testbench

- Serial-to-parallel receive path; the counterpart of the team's byte transmitter.
- Accepts an asynchronous serial line carrying frames of: start bit (0), 8 data bits LSB first, even parity bit (parity = XOR of the 8 data bits), stop bit (1).
- Samples each bit at its midpoint using a clock-per-bit divider.
- Presents each received byte on a valid/ack holding register, with parity, framing and overrun status.

---
 rtl/uart_receiver.sv | 133 +++++++++++++
 tb/tb_uart_receiver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receive path: 2-flop synchroniser, mid-bit sampling FSM for 8E1 / 8N1 frames,
// and a valid/ack holding register carrying parity, framing and overrun status.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b1
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       RxD,
    input  logic       RxD_ack,
    output logic [7:0] RxD_data,
    output logic       RxD_valid,
    output logic       RxD_parity_err,
    output logic       RxD_frame_err,
    output logic       RxD_overrun,
    output logic       RxD_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    state_t          r_state, w_next;
    logic            r_rx_meta, r_rxs;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_par_acc, r_par_bad;
    logic [7:0]      r_data;
    logic            r_valid, r_par_err, r_frame_err, r_overrun;
    logic            w_mid, w_end, w_sample_data, w_complete, w_cnt_clr;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
            r_state   <= S_IDLE;
        end else begin
            r_rx_meta <= RxD;
            r_rxs     <= r_rx_meta;
            r_state   <= w_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        w_next        = r_state;
        w_mid         = (r_cnt == HALF_CNT);
        w_end         = (r_cnt == LAST_CNT);
        w_sample_data = 1'b0;
        w_complete    = 1'b0;
        case (r_state)
            S_IDLE:      if (!r_rxs) w_next = S_START;
            S_START:     if (w_mid) w_next = r_rxs ? S_IDLE : S_DATA;
            S_DATA: begin
                w_sample_data = w_end;
                if (w_end && r_bit_idx == 3'd7) w_next = PARITY_EN ? S_PARITY : S_STOP;
            end
            S_PARITY:    if (w_end) w_next = S_STOP;
            S_STOP: begin
                w_complete = w_end;
                if (w_end) w_next = r_rxs ? S_IDLE : S_WAIT_HIGH;
            end
            S_WAIT_HIGH: if (r_rxs) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
        w_cnt_clr = (w_next != r_state) || w_sample_data;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par_acc <= 1'b0;
            r_par_bad <= 1'b0;
        end else begin
            if (w_cnt_clr || r_state == S_IDLE || r_state == S_WAIT_HIGH) r_cnt <= '0;
            else                                                           r_cnt <= r_cnt + 1'b1;

            if (r_state == S_START) begin
                r_bit_idx <= '0;
                r_par_acc <= 1'b0;
                r_par_bad <= 1'b0;
            end else if (w_sample_data) begin
                r_shift[r_bit_idx] <= r_rxs;
                r_par_acc          <= r_par_acc ^ r_rxs;
                r_bit_idx          <= r_bit_idx + 1'b1;
            end else if (r_state == S_PARITY && w_end) begin
                r_par_bad <= r_rxs ^ r_par_acc;
            end
        end
    end

    // A completing frame wins over a plain ack; an ack in the same cycle frees the slot for it.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_complete) begin
            if (!r_valid || RxD_ack) begin
                r_data      <= r_shift;
                r_par_err   <= r_par_bad;
                r_frame_err <= ~r_rxs;
                r_valid     <= 1'b1;
                if (RxD_ack) r_overrun <= 1'b0;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (RxD_ack && r_valid) begin
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
        end
    end

    assign RxD_data       = r_data;
    assign RxD_valid      = r_valid;
    assign RxD_parity_err = r_par_err;
    assign RxD_frame_err  = r_frame_err;
    assign RxD_overrun    = r_overrun;
    assign RxD_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench: one receiver at 4 clocks/bit with parity, one at 16 clocks/bit without parity.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd_a, ack_a, rxd_b, ack_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, perr_a, ferr_a, ovr_a, busy_a;
    logic       valid_b, perr_b, ferr_b, ovr_b, busy_b;
    int         n_chk = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    uart_receiver #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut_a (
        .Clk(clk), .Rst_n(rst_n), .RxD(rxd_a), .RxD_ack(ack_a),
        .RxD_data(data_a), .RxD_valid(valid_a), .RxD_parity_err(perr_a),
        .RxD_frame_err(ferr_a), .RxD_overrun(ovr_a), .RxD_busy(busy_a)
    );

    uart_receiver #(.CLKS_PER_BIT(16), .PARITY_EN(1'b0)) dut_b (
        .Clk(clk), .Rst_n(rst_n), .RxD(rxd_b), .RxD_ack(ack_b),
        .RxD_data(data_b), .RxD_valid(valid_b), .RxD_parity_err(perr_b),
        .RxD_frame_err(ferr_b), .RxD_overrun(ovr_b), .RxD_busy(busy_b)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rxd_b = v;
        else     rxd_a = v;
    endtask

    // Returns on the negedge that falls inside the receiver's stop-sample (completion) cycle.
    task automatic send_frame(input bit sel, input int cpb, input logic [7:0] d,
                              input bit with_par, input logic par, input logic stp);
        drive(sel, 1'b0);
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(sel, d[i]);
            repeat (cpb) @(negedge clk);
        end
        if (with_par) begin
            drive(sel, par);
            repeat (cpb) @(negedge clk);
        end
        drive(sel, stp);
        repeat (cpb) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input bit sel, input int max_cyc);
        int n = 0;
        while (((sel ? valid_b : valid_a) !== 1'b1) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, sel ? valid_b : valid_a, 1'b1);
    endtask

    task automatic pulse_ack(input bit sel);
        if (sel) ack_b = 1'b1; else ack_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
        ack_b = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        rxd_a = 1'b1;
        rxd_b = 1'b1;
        ack_a = 1'b0;
        ack_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data",  data_a,  8'h00);
        check("rst_valid", valid_a, 1'b0);
        check("rst_perr",  perr_a,  1'b0);
        check("rst_ferr",  ferr_a,  1'b0);
        check("rst_ovr",   ovr_a,   1'b0);
        check("rst_busy",  busy_a,  1'b0);
        check("rst_b_valid", valid_b, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Clean frame 0xA5, even parity 0
        send_frame(1'b0, 4, 8'hA5, 1'b1, 1'b0, 1'b1);
        wait_valid("a5_valid", 1'b0, 8);
        check("a5_data", data_a, 8'hA5);
        check("a5_perr", perr_a, 1'b0);
        check("a5_ferr", ferr_a, 1'b0);
        check("a5_busy", busy_a, 1'b0);
        pulse_ack(1'b0);
        check("a5_ack_valid", valid_a, 1'b0);
        check("a5_ack_data",  data_a,  8'hA5);

        // 0x07 has three ones, so correct parity is 1; send 0
        send_frame(1'b0, 4, 8'h07, 1'b1, 1'b0, 1'b1);
        wait_valid("p07_valid", 1'b0, 8);
        check("p07_data", data_a, 8'h07);
        check("p07_perr", perr_a, 1'b1);
        check("p07_ferr", ferr_a, 1'b0);
        pulse_ack(1'b0);
        check("p07_ack_perr",  perr_a,  1'b0);
        check("p07_ack_valid", valid_a, 1'b0);

        // 0x3C with stop bit 0, line held low afterwards
        send_frame(1'b0, 4, 8'h3C, 1'b1, 1'b0, 1'b0);
        wait_valid("f3c_valid", 1'b0, 8);
        check("f3c_data", data_a, 8'h3C);
        check("f3c_ferr", ferr_a, 1'b1);
        check("f3c_perr", perr_a, 1'b0);
        repeat (20) @(negedge clk);
        check("f3c_low_busy", busy_a, 1'b1);
        check("f3c_low_ovr",  ovr_a,  1'b0);
        rxd_a = 1'b1;
        repeat (6) @(negedge clk);
        check("f3c_high_busy", busy_a, 1'b0);
        check("f3c_high_data", data_a, 8'h3C);
        check("f3c_high_ovr",  ovr_a,  1'b0);
        pulse_ack(1'b0);
        send_frame(1'b0, 4, 8'h11, 1'b1, 1'b0, 1'b1);
        wait_valid("c11_valid", 1'b0, 8);
        check("c11_data", data_a, 8'h11);
        check("c11_ferr", ferr_a, 1'b0);
        check("c11_perr", perr_a, 1'b0);
        pulse_ack(1'b0);

        // Back-to-back 0x55, 0xAA without ack: second frame dropped
        send_frame(1'b0, 4, 8'h55, 1'b1, 1'b0, 1'b1);
        send_frame(1'b0, 4, 8'hAA, 1'b1, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("ovr_valid", valid_a, 1'b1);
        check("ovr_data",  data_a,  8'h55);
        check("ovr_flag",  ovr_a,   1'b1);
        pulse_ack(1'b0);
        check("ovr_ack_flag",  ovr_a,   1'b0);
        check("ovr_ack_valid", valid_a, 1'b0);

        // Same pair, ack landing exactly in the 0xAA completion cycle
        send_frame(1'b0, 4, 8'h55, 1'b1, 1'b0, 1'b1);
        send_frame(1'b0, 4, 8'hAA, 1'b1, 1'b0, 1'b1);
        pulse_ack(1'b0);
        check("ackc_valid", valid_a, 1'b1);
        check("ackc_data",  data_a,  8'hAA);
        check("ackc_ovr",   ovr_a,   1'b0);
        pulse_ack(1'b0);
        check("ackc_clr_valid", valid_a, 1'b0);

        // One-cycle glitch while idle: false start
        rxd_a = 1'b0;
        @(negedge clk);
        rxd_a = 1'b1;
        repeat (2) @(negedge clk);
        check("gl_busy_start", busy_a, 1'b1);
        repeat (10) @(negedge clk);
        check("gl_busy",  busy_a,  1'b0);
        check("gl_valid", valid_a, 1'b0);
        check("gl_perr",  perr_a,  1'b0);
        check("gl_ferr",  ferr_a,  1'b0);
        check("gl_ovr",   ovr_a,   1'b0);

        // Reset in the middle of the data bits of 0xF0
        rxd_a = 1'b0;
        repeat (4) @(negedge clk);
        repeat (12) @(negedge clk);
        check("mid_busy", busy_a, 1'b1);
        rst_n = 1'b0;
        rxd_a = 1'b1;
        #1;
        check("mid_rst_data",  data_a,  8'h00);
        check("mid_rst_valid", valid_a, 1'b0);
        check("mid_rst_busy",  busy_a,  1'b0);
        check("mid_rst_flags", {5'b0, perr_a, ferr_a, ovr_a}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(1'b0, 4, 8'h0F, 1'b1, 1'b0, 1'b1);
        wait_valid("r0f_valid", 1'b0, 8);
        check("r0f_data", data_a, 8'h0F);
        check("r0f_perr", perr_a, 1'b0);
        check("r0f_ferr", ferr_a, 1'b0);
        pulse_ack(1'b0);

        // 16 clocks/bit, no parity bit in the frame
        send_frame(1'b1, 16, 8'h0F, 1'b0, 1'b0, 1'b1);
        wait_valid("b0f_valid", 1'b1, 24);
        check("b0f_data", data_b, 8'h0F);
        check("b0f_perr", perr_b, 1'b0);
        check("b0f_ferr", ferr_b, 1'b0);
        check("b0f_busy", busy_b, 1'b0);
        pulse_ack(1'b1);
        check("b0f_ack_valid", valid_b, 1'b0);
        send_frame(1'b1, 16, 8'hC1, 1'b0, 1'b0, 1'b1);
        wait_valid("bc1_valid", 1'b1, 24);
        check("bc1_data", data_b, 8'hC1);
        check("bc1_perr", perr_b, 1'b0);
        check("bc1_ovr",  ovr_b,  1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
